// File: rtl/pipeline_probe_serializer_if.sv
// Probe capture / serial output bundle between the pipeline core and the pin wrapper.
// master drives the probe words and strobe, slave is the serializer.
interface pipeline_probe_serializer_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] probe_data;
    logic                      probe_strobe;
    logic                      busy;
    logic                      ser_data;
    logic                      ser_clk;
    logic                      ser_frame;
    logic [7:0]                drop_cnt;

    modport master (
        output probe_data, probe_strobe,
        input  busy, ser_data, ser_clk, ser_frame, drop_cnt
    );

    modport slave (
        input  probe_data, probe_strobe,
        output busy, ser_data, ser_clk, ser_frame, drop_cnt
    );
endinterface

// File: rtl/pipeline_probe_serializer.sv
// Snapshots CHANNELS probe words on a strobe and shifts them out bit-serially
// on data/clock/frame pins, followed by a CLK_DIV-cycle idle gap.
module pipeline_probe_serializer #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 2,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    pipeline_probe_serializer_if.slave    bus
);
    localparam int TOT       = CHANNELS * WIDTH;
    localparam int BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int POS_W     = (TOT > 1) ? $clog2(TOT) : 1;
    localparam int FIRST_POS = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             r_state;
    logic [TOT-1:0]     r_shadow;
    logic [BIT_W-1:0]   r_bit_idx;
    logic [CH_W-1:0]    r_ch_idx;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_busy;
    logic               r_ser_data;
    logic               r_ser_clk;
    logic               r_ser_frame;
    logic [7:0]         r_drop_cnt;

    logic               w_word_end;
    logic               w_frame_end;
    logic               w_div_end;
    logic [DIV_W-1:0]   w_nxt_div;
    logic [BIT_W-1:0]   w_nxt_bit;
    logic [CH_W-1:0]    w_nxt_ch;
    logic               w_nxt_data;

    function automatic logic [POS_W-1:0] f_pos(input logic [CH_W-1:0] ch, input logic [BIT_W-1:0] b);
        logic [POS_W-1:0] base;
        base = POS_W'(ch) * POS_W'(WIDTH);
        if (MSB_FIRST != 0) return base + POS_W'(WIDTH - 1) - POS_W'(b);
        else                return base + POS_W'(b);
    endfunction

    assign w_word_end  = (r_bit_idx == BIT_W'(WIDTH - 1));
    assign w_frame_end = w_word_end && (r_ch_idx == CH_W'(CHANNELS - 1));
    assign w_div_end   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_nxt_div   = r_div_cnt + 1'b1;
    assign w_nxt_bit   = w_word_end ? '0 : r_bit_idx + 1'b1;
    assign w_nxt_ch    = w_word_end ? r_ch_idx + 1'b1 : r_ch_idx;
    // Outputs are registered, so the bit for the upcoming slot is looked up one cycle early.
    assign w_nxt_data  = r_shadow[f_pos(w_nxt_ch, w_nxt_bit)];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_bit_idx   <= '0;
            r_ch_idx    <= '0;
            r_div_cnt   <= '0;
            r_busy      <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_clk   <= 1'b0;
            r_ser_frame <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (bus.probe_strobe && r_busy && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
            case (r_state)
                IDLE: begin
                    if (bus.probe_strobe) begin
                        r_shadow    <= bus.probe_data;
                        r_bit_idx   <= '0;
                        r_ch_idx    <= '0;
                        r_div_cnt   <= '0;
                        r_state     <= SHIFT;
                        r_busy      <= 1'b1;
                        r_ser_frame <= 1'b1;
                        r_ser_clk   <= 1'b0;
                        r_ser_data  <= bus.probe_data[FIRST_POS];
                    end
                end
                SHIFT: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_ser_clk <= 1'b0;
                        if (w_frame_end) begin
                            r_state     <= GAP;
                            r_ser_frame <= 1'b0;
                            r_ser_data  <= 1'b0;
                        end else begin
                            r_bit_idx  <= w_nxt_bit;
                            r_ch_idx   <= w_nxt_ch;
                            r_ser_data <= w_nxt_data;
                        end
                    end else begin
                        r_div_cnt <= w_nxt_div;
                        // High for the second half of each bit slot.
                        r_ser_clk <= !(w_nxt_div < DIV_W'(CLK_DIV / 2));
                    end
                end
                GAP: begin
                    if (w_div_end) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= w_nxt_div;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.ser_data  = r_ser_data;
    assign bus.ser_clk   = r_ser_clk;
    assign bus.ser_frame = r_ser_frame;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_pipeline_probe_serializer.sv
// Random-stimulus scoreboard bench: an LSB-first and an MSB-first serializer share one stimulus
// stream; expected bit streams are queued at capture and popped on each ser_clk rise.
module tb_pipeline_probe_serializer;
    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int CD  = 2;
    localparam int TOT = W * CH;
    localparam int FR  = W * CH * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_probe_serializer_if #(.WIDTH(W), .CHANNELS(CH)) bus0 ();
    pipeline_probe_serializer_if #(.WIDTH(W), .CHANNELS(CH)) bus1 ();
    assign bus1.probe_data   = bus0.probe_data;
    assign bus1.probe_strobe = bus0.probe_strobe;

    pipeline_probe_serializer #(.WIDTH(W), .CHANNELS(CH), .CLK_DIV(CD), .MSB_FIRST(0)) dut_lsb (
        .i_clk(clk), .i_reset(rst), .bus(bus0));
    pipeline_probe_serializer #(.WIDTH(W), .CHANNELS(CH), .CLK_DIV(CD), .MSB_FIRST(1)) dut_msb (
        .i_clk(clk), .i_reset(rst), .bus(bus1));

    // Reference model state: edge index of last accepted capture, saturating drop count.
    int cyc     = 0;
    int last_e0 = -1000;
    int drops   = 0;
    bit q0[$];
    bit q1[$];
    int checks  = 0;
    int errors  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [TOT-1:0] rnd();
        return TOT'($urandom);
    endfunction

    // Drive inputs for the next edge and advance the model for that edge.
    task automatic step(input bit s, input bit r, input logic [TOT-1:0] d);
        int ne;
        @(negedge clk);
        rst = r;
        bus0.probe_strobe = s;
        bus0.probe_data   = d;
        ne = cyc + 1;
        if (r) begin
            last_e0 = -1000;
            drops   = 0;
            q0.delete();
            q1.delete();
        end else if (s) begin
            if (ne >= last_e0 + FR + CD + 1) begin
                last_e0 = ne;
                for (int c = 0; c < CH; c++)
                    for (int b = 0; b < W; b++) begin
                        q0.push_back(d[c*W + b]);
                        q1.push_back(d[c*W + W - 1 - b]);
                    end
            end else if (drops < 255) begin
                drops++;
            end
        end
    endtask

    bit p0 = 1'b0, p1 = 1'b0;
    bit eb, ef, ec, e;
    int t;
    always @(posedge clk) begin
        #1;
        t  = cyc;
        eb = (t >= last_e0) && (t < last_e0 + FR + CD);
        ef = (t >= last_e0) && (t < last_e0 + FR);
        ec = ef && (((t - last_e0) % CD) >= CD / 2);
        chk("busy_lsb",  32'(bus0.busy),      32'(eb));
        chk("frame_lsb", 32'(bus0.ser_frame), 32'(ef));
        chk("sclk_lsb",  32'(bus0.ser_clk),   32'(ec));
        chk("drop_lsb",  32'(bus0.drop_cnt),  32'(drops));
        chk("busy_msb",  32'(bus1.busy),      32'(eb));
        chk("frame_msb", 32'(bus1.ser_frame), 32'(ef));
        chk("sclk_msb",  32'(bus1.ser_clk),   32'(ec));
        chk("drop_msb",  32'(bus1.drop_cnt),  32'(drops));
        if (!ef) begin
            chk("data_idle_lsb", 32'(bus0.ser_data), 32'd0);
            chk("data_idle_msb", 32'(bus1.ser_data), 32'd0);
        end
        if (!p0 && bus0.ser_clk === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL bit_lsb: unexpected ser_clk rise, no bit queued (edge %0d)", t);
            end else begin
                e = q0.pop_front();
                chk("bit_lsb", 32'(bus0.ser_data), 32'(e));
            end
        end
        if (!p1 && bus1.ser_clk === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL bit_msb: unexpected ser_clk rise, no bit queued (edge %0d)", t);
            end else begin
                e = q1.pop_front();
                chk("bit_msb", 32'(bus1.ser_data), 32'(e));
            end
        end
        p0 = (bus0.ser_clk === 1'b1);
        p1 = (bus1.ser_clk === 1'b1);
    end

    initial begin
        bus0.probe_strobe = 1'b0;
        bus0.probe_data   = '0;
        repeat (3) step(0, 1, rnd());
        step(0, 0, rnd());

        // Known words, LSB/MSB order; data keeps changing after capture.
        step(1, 0, {8'h3C, 8'hA5});
        repeat (FR + CD + 4) step(0, 0, rnd());
        step(1, 0, {8'h80, 8'h01});
        repeat (5) step(0, 0, rnd());
        step(1, 0, rnd()); step(0, 0, rnd());
        step(1, 0, rnd()); step(0, 0, rnd());
        step(1, 0, rnd());
        repeat (FR + CD + 4) step(0, 0, rnd());
        chk("drop_after_three", 32'(bus0.drop_cnt), 32'd3);

        // Held strobe: back-to-back frames and drop saturation.
        repeat (300) step(1, 0, rnd());
        repeat (FR + CD + 4) step(0, 0, rnd());
        chk("drop_saturated", 32'(bus0.drop_cnt), 32'd255);

        // Reset ten cycles into a frame, then a strobe right after release.
        step(1, 0, rnd());
        repeat (9) step(0, 0, rnd());
        step(0, 1, rnd());
        step(0, 0, rnd());
        chk("rst_busy",  32'(bus0.busy),      32'd0);
        chk("rst_frame", 32'(bus0.ser_frame), 32'd0);
        chk("rst_drop",  32'(bus0.drop_cnt),  32'd0);
        step(1, 0, rnd());
        repeat (FR + CD + 4) step(0, 0, rnd());

        repeat (400) step($urandom_range(0, 15) == 0, 0, rnd());
        repeat (FR + CD + 4) step(0, 0, rnd());
        chk("q_lsb_drained", 32'(q0.size()), 32'd0);
        chk("q_msb_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
